// File: rtl/traffic_lights_pkg.sv
// Shared types and constants for the traffic_lights command sequencer.
package traffic_lights_pkg;

  // Command encoding understood by traffic_lights cmd_type_i.
  typedef enum logic [2:0] {
    CmdOn        = 3'd0,
    CmdOff       = 3'd1,
    CmdBlink     = 3'd2,
    CmdSetGreen  = 3'd3,
    CmdSetRed    = 3'd4,
    CmdSetYellow = 3'd5
  } cmd_t;

  // MAINT_EXIT replays the APPLY sequence, so it needs no encoding of its own.
  typedef enum logic {
    SeqApply      = 1'b0,
    SeqMaintEnter = 1'b1
  } seq_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap,
    StDone
  } state_t;

  localparam logic [1:0] CFG_SEL_GREEN  = 2'd0;
  localparam logic [1:0] CFG_SEL_RED    = 2'd1;
  localparam logic [1:0] CFG_SEL_YELLOW = 2'd2;

  // Index of the final step (ON) of an APPLY sequence.
  localparam logic [2:0] LAST_APPLY_STEP = 3'd4;

  // The target treats a zero duration as invalid, so never hand it one.
  function automatic logic [15:0] clamp_nz(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/traffic_lights_cfg_regs.sv
// Host-writable timing registers plus a shadow copy frozen at sequence start.
module traffic_lights_cfg_regs
  import traffic_lights_pkg::*;
#(
  parameter logic [15:0] GREEN_DEF  = 16'd10,
  parameter logic [15:0] RED_DEF    = 16'd10,
  parameter logic [15:0] YELLOW_DEF = 16'd3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [1:0]  sel_i,
  input  logic [15:0] data_i,
  input  logic        snap_i,
  output logic [15:0] green_o,
  output logic [15:0] red_o,
  output logic [15:0] yellow_o
);

  logic [15:0] green_q, red_q, yellow_q;
  logic [15:0] green_d, red_d, yellow_d;
  logic [15:0] green_sh_q, red_sh_q, yellow_sh_q;

  // Decode a host write into the working registers; select 3 is ignored.
  always_comb begin
    green_d  = green_q;
    red_d    = red_q;
    yellow_d = yellow_q;
    if (we_i) begin
      case (sel_i)
        CFG_SEL_GREEN:  green_d  = clamp_nz(data_i);
        CFG_SEL_RED:    red_d    = clamp_nz(data_i);
        CFG_SEL_YELLOW: yellow_d = clamp_nz(data_i);
        default: ;
      endcase
    end
  end

  // Working registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      green_q  <= GREEN_DEF;
      red_q    <= RED_DEF;
      yellow_q <= YELLOW_DEF;
    end else begin
      green_q  <= green_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
    end
  end

  // Shadow snapshot: takes the pre-write working values at sequence start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      green_sh_q  <= GREEN_DEF;
      red_sh_q    <= RED_DEF;
      yellow_sh_q <= YELLOW_DEF;
    end else if (snap_i) begin
      green_sh_q  <= green_q;
      red_sh_q    <= red_q;
      yellow_sh_q <= yellow_q;
    end
  end

  assign green_o  = green_sh_q;
  assign red_o    = red_sh_q;
  assign yellow_o = yellow_sh_q;

endmodule

// File: rtl/traffic_lights_cmd_seq.sv
// Command sequencer driving one traffic_lights instance over cmd_type/valid/data.
module traffic_lights_cmd_seq
  import traffic_lights_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic [15:0] GREEN_DEF  = 16'd10,
  parameter logic [15:0] RED_DEF    = 16'd10,
  parameter logic [15:0] YELLOW_DEF = 16'd3,
  parameter bit          AUTO_APPLY = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_we_i,
  input  logic [1:0]  cfg_sel_i,
  input  logic [15:0] cfg_data_i,
  input  logic        apply_i,
  input  logic        maint_i,
  output logic [2:0]  cmd_type_o,
  output logic        cmd_valid_o,
  output logic [15:0] cmd_data_o,
  output logic        busy_o,
  output logic        maint_active_o,
  output logic        done_o
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t          state_q;
  seq_t            seq_q;
  logic [2:0]      step_q;
  logic [GapW-1:0] gap_q;
  cmd_t            cmd_type_q;
  logic            cmd_valid_q;
  logic [15:0]     cmd_data_q;
  logic            busy_q, done_q, maint_active_q;
  logic            pending_q, pending_d, boot_q;

  logic            maint_req, start, pend_clr, advance;
  seq_t            start_seq;
  logic [2:0]      last_step, nxt_step;
  logic [15:0]     sh_green, sh_red, sh_yellow;

  traffic_lights_cfg_regs #(
    .GREEN_DEF  (GREEN_DEF),
    .RED_DEF    (RED_DEF),
    .YELLOW_DEF (YELLOW_DEF)
  ) u_cfg_regs (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (cfg_we_i),
    .sel_i    (cfg_sel_i),
    .data_i   (cfg_data_i),
    .snap_i   (start),
    .green_o  (sh_green),
    .red_o    (sh_red),
    .yellow_o (sh_yellow)
  );

  // Step ROM for the APPLY sequence: BLINK, SET_GREEN, SET_RED, SET_YELLOW, ON.
  function automatic cmd_t step_cmd(input logic [2:0] s);
    case (s)
      3'd0:    return CmdBlink;
      3'd1:    return CmdSetGreen;
      3'd2:    return CmdSetRed;
      3'd3:    return CmdSetYellow;
      default: return CmdOn;
    endcase
  endfunction

  function automatic logic [15:0] step_data(input logic [2:0] s, input logic [15:0] g,
                                            input logic [15:0] r, input logic [15:0] y);
    case (s)
      3'd1:    return g;
      3'd2:    return r;
      3'd3:    return y;
      default: return 16'd0;
    endcase
  endfunction

  // Request arbitration (only acted on in IDLE) and step bookkeeping.
  always_comb begin
    maint_req = (maint_i != maint_active_q);
    start     = (state_q == StIdle) && (maint_req || (pending_q && !maint_active_q));
    start_seq = (maint_req && maint_i) ? SeqMaintEnter : SeqApply;
    pend_clr  = start && (start_seq == SeqApply);
    last_step = (seq_q == SeqMaintEnter) ? 3'd0 : LAST_APPLY_STEP;
    nxt_step  = step_q + 3'd1;
    advance   = ((state_q == StIssue) && (GAP_CYCLES == 0)) ||
                ((state_q == StGap) && (gap_q == '0));
    // A request arriving in the start cycle is a fresh one and survives the clear.
    pending_d = (pending_q && !pend_clr) || apply_i || boot_q;
  end

  // Pending APPLY flag; boot_q injects the automatic post-reset request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      boot_q    <= AUTO_APPLY;
    end else begin
      pending_q <= pending_d;
      boot_q    <= 1'b0;
    end
  end

  // Sequencer FSM with registered command, busy, done and maint outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      seq_q          <= SeqApply;
      step_q         <= 3'd0;
      gap_q          <= '0;
      cmd_valid_q    <= 1'b0;
      cmd_type_q     <= CmdOn;
      cmd_data_q     <= 16'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      maint_active_q <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CmdOn;
      cmd_data_q  <= 16'd0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            // Both sequences open with BLINK, which carries no data.
            state_q     <= StIssue;
            seq_q       <= start_seq;
            step_q      <= 3'd0;
            busy_q      <= 1'b1;
            cmd_valid_q <= 1'b1;
            cmd_type_q  <= CmdBlink;
          end
        end
        StIssue: begin
          if (GAP_CYCLES != 0) begin
            state_q <= StGap;
            gap_q   <= GapLast;
          end
        end
        StGap: begin
          if (gap_q != '0) gap_q <= gap_q - GapW'(1);
        end
        StDone: state_q <= StIdle;
      endcase
      if (advance) begin
        if (step_q == last_step) begin
          state_q        <= StDone;
          busy_q         <= 1'b0;
          done_q         <= 1'b1;
          maint_active_q <= (seq_q == SeqMaintEnter);
        end else begin
          state_q     <= StIssue;
          step_q      <= nxt_step;
          cmd_valid_q <= 1'b1;
          cmd_type_q  <= step_cmd(nxt_step);
          cmd_data_q  <= step_data(nxt_step, sh_green, sh_red, sh_yellow);
        end
      end
    end
  end

  assign cmd_type_o     = cmd_type_q;
  assign cmd_valid_o    = cmd_valid_q;
  assign cmd_data_o     = cmd_data_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign maint_active_o = maint_active_q;

endmodule

// File: tb/tb_traffic_lights_cmd_seq.sv
// Self-checking bench: directed scenarios plus random traffic against a timeline model.
module tb_traffic_lights_cmd_seq;

  localparam int G   = 2;
  localparam int PER = G + 1;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [1:0]  cfg_sel_i = 2'd0;
  logic [15:0] cfg_data_i = 16'd0;
  logic        apply_i = 1'b0;
  logic        maint_i = 1'b0;
  logic [2:0]  cmd_type_o;
  logic        cmd_valid_o;
  logic [15:0] cmd_data_o;
  logic        busy_o, maint_active_o, done_o;

  always #5 clk = ~clk;

  traffic_lights_cmd_seq #(
    .GAP_CYCLES (G),
    .GREEN_DEF  (16'd10),
    .RED_DEF    (16'd10),
    .YELLOW_DEF (16'd3),
    .AUTO_APPLY (1'b1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .cfg_we_i       (cfg_we_i),
    .cfg_sel_i      (cfg_sel_i),
    .cfg_data_i     (cfg_data_i),
    .apply_i        (apply_i),
    .maint_i        (maint_i),
    .cmd_type_o     (cmd_type_o),
    .cmd_valid_o    (cmd_valid_o),
    .cmd_data_o     (cmd_data_o),
    .busy_o         (busy_o),
    .maint_active_o (maint_active_o),
    .done_o         (done_o)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a sequence is a list of commands launched at edge m_start,
  // command i appears at m_start + i*PER, done at m_start + n*PER.
  int e;
  bit m_active, m_pend, m_boot, m_maint, m_tgt;
  int m_start, m_n;
  int m_type[5];
  int m_data[5];
  int m_g, m_r, m_y;
  int n_cmds;
  int last_data[8];

  function automatic int clamp1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    e = 0; m_active = 0; m_pend = 0; m_boot = 1; m_maint = 0; m_tgt = 0;
    m_g = 10; m_r = 10; m_y = 3;
  endtask

  task automatic load_apply();
    m_n = 5;
    m_type[0] = 2; m_data[0] = 0;
    m_type[1] = 3; m_data[1] = m_g;
    m_type[2] = 4; m_data[2] = m_r;
    m_type[3] = 5; m_data[3] = m_y;
    m_type[4] = 0; m_data[4] = 0;
  endtask

  task automatic model_edge();
    bit clr;
    clr = 0;
    e++;
    if (m_active && (e - 1) > m_start + m_n * PER) m_active = 0;
    if (!m_active) begin
      if (maint_i != m_maint) begin
        m_active = 1; m_start = e;
        if (maint_i) begin
          m_n = 1; m_type[0] = 2; m_data[0] = 0; m_tgt = 1;
        end else begin
          load_apply(); m_tgt = 0; clr = 1;
        end
      end else if (m_pend && !m_maint) begin
        m_active = 1; m_start = e; load_apply(); m_tgt = 0; clr = 1;
      end
    end
    m_pend = (m_pend && !clr) || apply_i || m_boot;
    m_boot = 0;
    if (cfg_we_i) begin
      case (cfg_sel_i)
        2'd0: m_g = clamp1(int'(cfg_data_i));
        2'd1: m_r = clamp1(int'(cfg_data_i));
        2'd2: m_y = clamp1(int'(cfg_data_i));
        default: ;
      endcase
    end
    if (m_active && e == m_start + m_n * PER) m_maint = m_tgt;
  endtask

  task automatic tick();
    int k, span;
    logic [19:0] ev;
    logic eb, ed;
    @(posedge clk);
    model_edge();
    #1;
    ev = '0; eb = 0; ed = 0;
    if (m_active) begin
      k = e - m_start;
      span = m_n * PER;
      if (k < span) begin
        eb = 1;
        if (k % PER == 0) ev = {1'b1, 3'(m_type[k / PER]), 16'(m_data[k / PER])};
      end else if (k == span) begin
        ed = 1;
      end
    end
    check("cmd", {12'd0, cmd_valid_o, cmd_type_o, cmd_data_o}, {12'd0, ev});
    check("busy", busy_o, eb);
    check("done", done_o, ed);
    check("maint_active", maint_active_o, m_maint);
    if (cmd_valid_o) begin
      n_cmds++;
      last_data[cmd_type_o] = int'(cmd_data_o);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      apply_i = 0; cfg_we_i = 0;
      tick();
    end
  endtask

  task automatic pulse_apply();
    apply_i = 1; tick(); apply_i = 0;
  endtask

  task automatic write_cfg(input logic [1:0] sel, input logic [15:0] val);
    cfg_we_i = 1; cfg_sel_i = sel; cfg_data_i = val; tick(); cfg_we_i = 0;
  endtask

  // Fresh boot sequence after reset release, checked against fixed timing.
  task automatic boot_check();
    int bc[5] = '{2, 5, 8, 11, 14};
    int bt[5] = '{2, 3, 4, 5, 0};
    int bd[5] = '{0, 10, 10, 3, 0};
    int hit;
    for (int c = 1; c <= 18; c++) begin
      apply_i = 0; cfg_we_i = 0;
      tick();
      hit = -1;
      for (int i = 0; i < 5; i++) if (bc[i] == c) hit = i;
      check("boot_valid", cmd_valid_o, hit >= 0);
      if (hit >= 0) check("boot_cmd", {cmd_type_o, cmd_data_o}, {3'(bt[hit]), 16'(bd[hit])});
      check("boot_done", done_o, c == 17);
    end
  endtask

  // Reset raised mid-cycle: outputs must clear before any clock edge.
  task automatic async_reset_check();
    #2 rst_i = 1;
    #1;
    check("arst_valid", cmd_valid_o, 1'b0);
    check("arst_busy", busy_o, 1'b0);
    check("arst_maint", maint_active_o, 1'b0);
    check("arst_cmd", {cmd_type_o, cmd_data_o}, 19'd0);
    check("arst_done", done_o, 1'b0);
    apply_i = 0; cfg_we_i = 0;
    @(posedge clk);
    @(negedge clk);
    rst_i = 0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    bit found;
    n_cmds = 0;
    for (int i = 0; i < 8; i++) last_data[i] = -1;
    #2 rst_i = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", cmd_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_maint", maint_active_o, 1'b0);
    @(negedge clk);
    rst_i = 0;
    model_reset();
    boot_check();
    run(4);

    // Written registers reach the next sequence, zero clamps to one.
    write_cfg(2'd1, 16'd25);
    pulse_apply();
    run(20);
    check("red25", last_data[4], 25);
    write_cfg(2'd0, 16'd0);
    pulse_apply();
    run(20);
    check("green_clamp", last_data[3], 1);

    // Write during a sequence only affects the following one.
    pulse_apply();
    tick();
    write_cfg(2'd2, 16'd7);
    run(20);
    check("yellow_old", last_data[5], 3);
    pulse_apply();
    run(20);
    check("yellow_new", last_data[5], 7);

    // Maintenance entry, deferred apply, exit.
    base = n_cmds;
    maint_i = 1;
    run(10);
    check("maint_enter_cmds", n_cmds - base, 1);
    check("maint_on", maint_active_o, 1'b1);
    base = n_cmds;
    pulse_apply();
    run(10);
    check("maint_apply_held", n_cmds - base, 0);
    maint_i = 0;
    run(25);
    check("maint_exit_cmds", n_cmds - base, 5);
    check("maint_off", maint_active_o, 1'b0);
    base = n_cmds;
    run(20);
    check("pending_consumed", n_cmds - base, 0);

    // Several applies while busy collapse into one more sequence.
    base = n_cmds;
    pulse_apply();
    run(3);
    pulse_apply();
    run(2);
    pulse_apply();
    run(2);
    pulse_apply();
    run(50);
    check("apply_collapse", n_cmds - base, 10);

    // Async reset during the gap after SET_RED, then a fresh default sequence.
    pulse_apply();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_active && (e - m_start) == 2 * PER + 1) found = 1;
      else run(1);
    end
    check("arst_wait", found, 1'b1);
    async_reset_check();
    boot_check();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      apply_i    = ($urandom_range(0, 19) == 0);
      cfg_we_i   = ($urandom_range(0, 7) == 0);
      cfg_sel_i  = 2'($urandom_range(0, 3));
      cfg_data_i = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 59) == 0) maint_i = ~maint_i;
      tick();
      if ($urandom_range(0, 699) == 0) async_reset_check();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
